riscv_nn_hwloop_ctrl: RTL and testbench

Hardware-loop controller that sits directly downstream of the hardware-loop register file and consumes its start, end and counter outputs. It compares the PC of the instruction leaving decode against every loop end address and selects the innermost active loop. It then holds a jump request to the prefetcher until that request is acknowledged. On acknowledge it emits the one-hot decrement strobe that the register file uses to count down the iteration.

---
 rtl/riscv_nn_hwloop_pkg.sv | 15 +
 rtl/riscv_nn_hwloop_match.sv | 35 +++
 rtl/riscv_nn_hwloop_ctrl.sv | 90 +++++++++
 tb/tb_riscv_nn_hwloop_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_nn_hwloop_pkg.sv
// Shared definitions for the hardware-loop controller and the loop register file.
// Both blocks import N_REGS from here so their loop counts cannot drift apart.
package riscv_nn_hwloop_pkg;

  localparam int unsigned HWLP_N_REGS = 2;

  // A loop with fewer than this many iterations left falls through instead of jumping.
  localparam logic [31:0] HWLP_MIN_JUMP_CNT = 32'd2;

  typedef enum logic {
    IDLE = 1'b0,
    JUMP = 1'b1
  } hwlp_state_e;

endpackage

// File: rtl/riscv_nn_hwloop_match.sv
// Compares the decode PC against every loop end and picks the innermost (lowest index) hit.
// Purely combinational; returns the winner both as a one-hot select and as an index.
module riscv_nn_hwloop_match
  import riscv_nn_hwloop_pkg::*;
#(
  parameter int unsigned N_REGS     = HWLP_N_REGS,
  parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic [31:0]              current_pc_i,
  input  logic [N_REGS-1:0][31:0]  hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]  hwlp_counter_i,
  output logic                     any_match,
  output logic [N_REGS-1:0]        sel,
  output logic [N_REG_BITS-1:0]    idx
);

  logic [N_REGS-1:0]                 match;
  logic [N_REGS-1:0][N_REG_BITS-1:0] idx_term;
  logic [N_REGS:0][N_REG_BITS-1:0]   idx_chain;

  assign idx_chain[0] = '0;

  for (genvar k = 0; k < N_REGS; k++) begin : g_loop
    assign match[k]        = (current_pc_i == hwlp_end_addr_i[k]) &&
                             (hwlp_counter_i[k] >= HWLP_MIN_JUMP_CNT);
    assign idx_term[k]     = sel[k] ? N_REG_BITS'(k) : '0;
    assign idx_chain[k+1]  = idx_chain[k] | idx_term[k];
  end

  // Isolate the lowest set bit: loop 0 is the innermost loop and wins ties.
  assign sel       = match & (~match + N_REGS'(1));
  assign any_match = |match;
  assign idx       = idx_chain[N_REGS];

endmodule

// File: rtl/riscv_nn_hwloop_ctrl.sv
// Hardware-loop controller: latches the winning loop's start address, holds a jump request
// to the prefetcher until it is acknowledged, and then strobes that loop's decrement.
module riscv_nn_hwloop_ctrl
  import riscv_nn_hwloop_pkg::*;
#(
  parameter int unsigned N_REGS     = HWLP_N_REGS,
  parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             current_pc_i,
  input  logic                    id_valid_i,
  input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_counter_i,
  input  logic                    hwlp_jump_ack_i,
  input  logic                    flush_i,
  output logic                    hwlp_jump_o,
  output logic [31:0]             hwlp_targ_addr_o,
  output logic [N_REGS-1:0]       hwlp_dec_cnt_o,
  output logic                    hwlp_busy_o
);

  hwlp_state_e             state_q, state_d;
  logic [N_REGS-1:0]       sel_q, sel_d;
  logic [31:0]             targ_q, targ_d;

  logic                    any_match;
  logic [N_REGS-1:0]       match_sel;
  logic [N_REG_BITS-1:0]   match_idx;

  riscv_nn_hwloop_match #(
    .N_REGS     (N_REGS),
    .N_REG_BITS (N_REG_BITS)
  ) u_match (
    .current_pc_i    (current_pc_i),
    .hwlp_end_addr_i (hwlp_end_addr_i),
    .hwlp_counter_i  (hwlp_counter_i),
    .any_match       (any_match),
    .sel             (match_sel),
    .idx             (match_idx)
  );

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    targ_d           = targ_q;
    hwlp_jump_o      = 1'b0;
    hwlp_busy_o      = 1'b0;
    hwlp_targ_addr_o = '0;
    hwlp_dec_cnt_o   = '0;

    unique case (state_q)
      IDLE: begin
        if (id_valid_i && any_match && !flush_i) begin
          state_d = JUMP;
          sel_d   = match_sel;
          targ_d  = hwlp_start_addr_i[match_idx];
        end
      end
      JUMP: begin
        hwlp_jump_o      = 1'b1;
        hwlp_busy_o      = 1'b1;
        hwlp_targ_addr_o = targ_q;
        // Flush and reset both drop the jump without charging an iteration.
        if (flush_i) begin
          state_d = IDLE;
        end else if (hwlp_jump_ack_i) begin
          state_d = IDLE;
          if (!rst) begin
            hwlp_dec_cnt_o = sel_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      targ_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      targ_q  <= targ_d;
    end
  end

endmodule

// File: tb/tb_riscv_nn_hwloop_ctrl.sv
// Randomized and directed bench for riscv_nn_hwloop_ctrl with a queue-based scoreboard.
// The bench also plays the loop register file, counting down on each decrement strobe.
module tb_riscv_nn_hwloop_ctrl;

  localparam int unsigned N = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         pc;
  logic                id_valid;
  logic [N-1:0][31:0]  start_addr;
  logic [N-1:0][31:0]  end_addr;
  logic [N-1:0][31:0]  cnt;
  logic                ack;
  logic                flush;
  logic                jump;
  logic [31:0]         targ;
  logic [N-1:0]        dec;
  logic                busy;

  always #5 clk = ~clk;

  riscv_nn_hwloop_ctrl #(
    .N_REGS (N)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .current_pc_i      (pc),
    .id_valid_i        (id_valid),
    .hwlp_start_addr_i (start_addr),
    .hwlp_end_addr_i   (end_addr),
    .hwlp_counter_i    (cnt),
    .hwlp_jump_ack_i   (ack),
    .flush_i           (flush),
    .hwlp_jump_o       (jump),
    .hwlp_targ_addr_o  (targ),
    .hwlp_dec_cnt_o    (dec),
    .hwlp_busy_o       (busy)
  );

  typedef struct packed {
    logic          jump;
    logic          busy;
    logic [31:0]   targ;
    logic [N-1:0]  dec;
  } obs_t;

  obs_t  exp_q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    dec_seen = 0;
  string phase    = "init";

  // Reference model: "is a jump outstanding, to where, charged to which loop".
  bit          m_known = 1'b0;
  bit          m_pend  = 1'b0;
  logic [31:0] m_targ  = '0;
  int          m_loop  = 0;
  bit          rf_auto = 1'b0;

  function automatic int find_winner();
    for (int k = 0; k < int'(N); k++) begin
      if (pc == end_addr[k] && cnt[k] >= 32'd2) return k;
    end
    return -1;
  endfunction

  task automatic cycle();
    obs_t         e;
    int           w;
    logic [N-1:0] dec_exp;
    dec_exp = '0;
    if (m_pend && ack && !flush && !rst) dec_exp = N'(1) << m_loop;
    e.jump = m_pend;
    e.busy = m_pend;
    e.targ = m_pend ? m_targ : 32'h0;
    e.dec  = dec_exp;
    if (m_known) exp_q.push_back(e);
    w = find_winner();
    @(posedge clk);
    if (rf_auto) begin
      for (int k = 0; k < int'(N); k++) begin
        if (dec_exp[k]) cnt[k] = cnt[k] - 32'd1;
      end
    end
    if (rst) begin
      m_pend  = 1'b0;
      m_known = 1'b1;
    end else if (m_pend) begin
      if (flush || ack) m_pend = 1'b0;
    end else if (m_known && id_valid && !flush && w >= 0) begin
      m_pend = 1'b1;
      m_targ = start_addr[w];
      m_loop = w;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    rst      = 1'b0;
    id_valid = 1'b0;
    ack      = 1'b0;
    flush    = 1'b0;
    pc       = 32'hDEAD_0000;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h100;
      1:       return 32'h200;
      2:       return 32'h204;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] pick_cnt();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'd2;
      3:       return 32'd3;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: compares whatever the DUT presents against the next queued expectation.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{jump: jump, busy: busy, targ: targ, dec: dec};
        if (a.dec != '0) dec_seen++;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s t=%0t got jump=%b busy=%b targ=%h dec=%b, want jump=%b busy=%b targ=%h dec=%b",
                   phase, $time, a.jump, a.busy, a.targ, a.dec, e.jump, e.busy, e.targ, e.dec);
        end
      end
    end
  end

  initial begin
    quiet();
    rst        = 1'b1;
    start_addr = '0;
    end_addr   = '0;
    cnt        = '0;
    @(negedge clk);

    phase = "reset";
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1; id_valid = 1'b1; ack = 1'($urandom); flush = 1'($urandom);
      pc = pick_addr();
      for (int k = 0; k < int'(N); k++) begin
        start_addr[k] = $urandom(); end_addr[k] = pc; cnt[k] = 32'd7;
      end
      cycle();
    end
    quiet(); cycle();

    phase = "basic";
    rf_auto = 1'b1;
    start_addr[0] = 32'h0F0; end_addr[0] = 32'h100; cnt[0] = 32'd5;
    start_addr[1] = 32'h500; end_addr[1] = 32'hFFF0; cnt[1] = 32'd9;
    pc = 32'h100; id_valid = 1'b1; cycle();
    pc = 32'h104; id_valid = 1'b0; cycle(); cycle();
    ack = 1'b1; cycle();
    ack = 1'b0; cycle(); cycle();

    phase = "last_iter";
    cnt[0] = 32'd1; pc = 32'h100; id_valid = 1'b1; cycle(); cycle();
    cnt[0] = 32'd0; cycle(); cycle();
    id_valid = 1'b0; cycle();

    phase = "nested";
    start_addr[0] = 32'h1C0; start_addr[1] = 32'h180;
    end_addr[0] = 32'h200; end_addr[1] = 32'h200; cnt[0] = 32'd3; cnt[1] = 32'd4;
    pc = 32'h200; id_valid = 1'b1; cycle();
    id_valid = 1'b0; cycle();
    ack = 1'b1; cycle();
    ack = 1'b0; cycle();

    phase = "flush";
    cnt[0] = 32'd3;
    id_valid = 1'b1; flush = 1'b1; cycle();
    flush = 1'b0; cycle();
    id_valid = 1'b0; cycle();
    flush = 1'b1; cycle();
    flush = 1'b0; id_valid = 1'b1; cycle();
    id_valid = 1'b0; flush = 1'b1; ack = 1'b1; cycle();
    flush = 1'b0; ack = 1'b0; cycle(); cycle();

    phase = "reset_mid_jump";
    id_valid = 1'b1; cycle();
    id_valid = 1'b0; rst = 1'b1; ack = 1'b1; cycle();
    quiet(); cycle(); cycle();

    phase = "single_instr";
    start_addr[0] = 32'h300; end_addr[0] = 32'h300; cnt[0] = 32'd3;
    end_addr[1] = 32'hFFF0;
    #3;
    dec_seen = 0;
    @(negedge clk);
    pc = 32'h300; id_valid = 1'b1; ack = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    quiet();
    #3;
    checks++;
    if (dec_seen != 2) begin
      errors++;
      $display("FAIL single_instr_dec_count got %0d pulses, want 2", dec_seen);
    end
    @(negedge clk);

    phase = "random";
    rf_auto = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      id_valid = 1'($urandom);
      ack      = 1'($urandom);
      flush    = ($urandom_range(0, 9) == 0);
      pc       = pick_addr();
      for (int k = 0; k < int'(N); k++) begin
        start_addr[k] = $urandom();
        end_addr[k]   = pick_addr();
        cnt[k]        = pick_cnt();
      end
      cycle();
    end

    phase = "drain";
    quiet(); cycle(); cycle();
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending entries, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
